rom_fetch_unit: RTL and testbench
=================================

Name: rom_fetch_unit

Overview:
Instruction fetch front-end between the program ROM and the CPU decoder.
- Drives the ROM address bus from an internal program counter (PC).
- Compensates for the ROM's one-cycle synchronous read latency.
- Buffers fetched bytes, tagged with their addresses, in a small FIFO.
- Delivers bytes to the decoder over a valid/ready handshake.
- Supports branch redirect with flush of all buffered and in-flight bytes.

Parameters:
ADDR_WIDTH, 8, ROM address width; the PC wraps modulo 2**ADDR_WIDTH.
DATA_WIDTH, 8, ROM and instruction byte width.
FIFO_DEPTH, 4, prefetch buffer entries; must be a power of 2 and at least 2.
RESET_VECTOR, 8'h00, PC value after reset.

Ports:
CLK  in  1  system clock, rising edge.
RESET  in  1  asynchronous, active-low reset.
ROM_ADDR  out  ADDR_WIDTH  registered address to the ROM; the ROM samples it on the rising edge.
ROM_DATA  in  DATA_WIDTH  ROM read data; valid the cycle after the address was sampled.
BRANCH_REQ  in  1  single-cycle redirect strobe.
BRANCH_ADDR  in  ADDR_WIDTH  redirect target; sampled when BRANCH_REQ=1.
INSTR_DATA  out  DATA_WIDTH  FIFO head byte.
INSTR_ADDR  out  ADDR_WIDTH  address of the FIFO head byte.
INSTR_VALID  out  1  FIFO not empty.
INSTR_READY  in  1  decoder accepts the head byte when INSTR_VALID=1 and INSTR_READY=1.

Behaviour:
- Reset (RESET=0, asynchronous):
  - PC=RESET_VECTOR, so ROM_ADDR=RESET_VECTOR.
  - pend=0, FIFO empty, INSTR_VALID=0.
  - INSTR_DATA=0, INSTR_ADDR=0.
  - Reset mid-operation discards all pending and buffered data.
- Issue: ROM_ADDR is the PC register. issue = !BRANCH_REQ && (count + pend < FIFO_DEPTH).
  - At an edge with issue=1: pend<=1, pend_addr<=PC, PC<=PC+1. The ROM latches rom[PC] at the same edge.
  - At an edge with issue=0: pend<=0 and PC holds.
- Capture: at an edge with pend=1 and BRANCH_REQ=0, push {ROM_DATA, pend_addr} into the FIFO.
  - The issue credit guarantees a push never meets a full FIFO. Credit is conservative: a same-cycle pop is not counted.
- Latency: 2 rising edges from an address being issued to INSTR_VALID. After reset release, the byte at RESET_VECTOR is valid after the 2nd edge.
- Throughput: 1 byte per cycle in steady state when INSTR_READY is held at 1.
- Pop: at an edge with INSTR_VALID && INSTR_READY && !BRANCH_REQ, the head advances. Simultaneous push and pop leaves count unchanged.
- Branch: at an edge with BRANCH_REQ=1, all of the following happen and override push, pop and issue in that cycle:
  - FIFO is flushed (count=0).
  - pend=0; the in-flight byte is squashed.
  - PC<=BRANCH_ADDR.
  - Result: INSTR_VALID=0 for the next 2 cycles, then the first byte from BRANCH_ADDR appears.
- Wrap-around: the PC increments modulo 2**ADDR_WIDTH (8'hFF -> 8'h00). FIFO pointers wrap modulo FIFO_DEPTH.
- INSTR_DATA and INSTR_ADDR reflect the FIFO head combinationally. Their value is don't-care while INSTR_VALID=0.
- No data is dropped or duplicated except by an explicit branch flush.

Optional Feature:
Macro ROM_FETCH_HALT_EN.
- Defined: adds input port HALT (1 bit).
  - HALT=1 forces issue=0 and freezes the PC.
  - An already-pending byte is still captured; pop continues normally.
  - BRANCH_REQ still takes effect during HALT.
- Undefined: no HALT port; issue depends only on credit and BRANCH_REQ.

Decomposition:
- Package rom_fetch_pkg:
  - Constants: FETCH_ADDR_W=8, FETCH_DATA_W=8, FETCH_RESET_VECTOR=8'h00.
  - Typedef fetch_entry_t = {data, addr}.
- Sub-module fetch_fifo:
  - Parameterised synchronous FIFO of fetch_entry_t with push, pop, flush, count and empty.
  - Flush has priority over push and pop.
  - The top level holds the PC, pend and credit logic.

Test Plan:
- Reset release with ROM[0..3]=A0,A1,A2,A3 and READY=1 -> ROM_ADDR goes 00,01,02,03; INSTR_VALID rises after the 2nd edge; bytes A0,A1,A2,A3 appear with INSTR_ADDR 00..03, one per cycle.
- READY=0 from reset -> FIFO fills to 4 entries, ROM_ADDR stalls at 04, no further issue. Then READY=1 -> A0..A3 drain in order, then 04 onward, no gaps beyond 2 cycles.
- Branch to 8'h40 while the FIFO holds 3 bytes and one is pending -> INSTR_VALID=0 for 2 cycles; next byte is rom[40] with INSTR_ADDR=40; no stale byte ever appears.
- Branch to 8'hFE with READY=1 -> INSTR_ADDR sequence FE, FF, 00, 01 (wrap).
- Assert RESET mid-stream with the FIFO half full -> INSTR_VALID=0 and ROM_ADDR=00 immediately; fetch restarts from 00.
- ROM_FETCH_HALT_EN defined, HALT=1 for 5 cycles with READY=1 -> the pending byte is delivered, then INSTR_VALID=0 and ROM_ADDR is frozen; after HALT=0, fetch resumes at the next sequential address.

Source files
------------

// File: rtl/rom_fetch_pkg.sv
// Shared constants and the prefetch buffer entry type for the ROM fetch front-end.
package rom_fetch_pkg;

   localparam int FETCH_ADDR_W = 8;
   localparam int FETCH_DATA_W = 8;
   localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_VECTOR = 8'h00;

   typedef struct packed {
      logic [FETCH_DATA_W-1:0] data;
      logic [FETCH_ADDR_W-1:0] addr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched bytes; flush wins over push and pop.
// DEPTH must be a power of 2 so the pointers wrap naturally.
module fetch_fifo
   import rom_fetch_pkg::*;
#(
   parameter type entry_t = fetch_entry_t,
   parameter int  DEPTH   = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  entry_t                 push_entry,
   input  logic                   pop,
   input  logic                   flush,
   output entry_t                 head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   // An empty buffer presents zeros so the head is clean straight out of reset.
   assign head = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/rom_fetch_unit.sv
// Instruction fetch front-end: PC-driven ROM reads, one-cycle latency capture, prefetch FIFO.
// Define ROM_FETCH_HALT_EN to add a HALT input that stops issuing new ROM reads.
module rom_fetch_unit
   import rom_fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH   = FETCH_ADDR_W,
   parameter int                    DATA_WIDTH   = FETCH_DATA_W,
   parameter int                    FIFO_DEPTH   = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = FETCH_RESET_VECTOR
) (
   input  logic                  CLK,
   input  logic                  RESET,
   output logic [ADDR_WIDTH-1:0] ROM_ADDR,
   input  logic [DATA_WIDTH-1:0] ROM_DATA,
   input  logic                  BRANCH_REQ,
   input  logic [ADDR_WIDTH-1:0] BRANCH_ADDR,
   output logic [DATA_WIDTH-1:0] INSTR_DATA,
   output logic [ADDR_WIDTH-1:0] INSTR_ADDR,
   output logic                  INSTR_VALID,
   input  logic                  INSTR_READY
`ifdef ROM_FETCH_HALT_EN
   ,
   input  logic                  HALT
`endif
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [ADDR_WIDTH-1:0] addr;
   } entry_t;

   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] pend_addr;
   logic                  pend;
   logic [CNT_W-1:0]      count;
   logic [CNT_W-1:0]      occupancy;
   logic                  halted;
   logic                  issue;
   logic                  push;
   logic                  pop;
   logic                  empty;
   entry_t                push_entry;
   entry_t                head;

`ifdef ROM_FETCH_HALT_EN
   assign halted = HALT;
`else
   assign halted = 1'b0;
`endif

   // Credit counts the in-flight byte but not a same-cycle pop, so a push can never meet a full FIFO.
   assign occupancy = count + CNT_W'(pend);
   assign issue     = !BRANCH_REQ && !halted && (occupancy < CNT_W'(FIFO_DEPTH));

   assign push       = pend && !BRANCH_REQ;
   assign push_entry = '{data: ROM_DATA, addr: pend_addr};
   assign pop        = INSTR_VALID && INSTR_READY && !BRANCH_REQ;

   assign ROM_ADDR    = pc;
   assign INSTR_VALID = !empty;
   assign INSTR_DATA  = head.data;
   assign INSTR_ADDR  = head.addr;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         pc        <= RESET_VECTOR;
         pend      <= 1'b0;
         pend_addr <= '0;
      end else if (BRANCH_REQ) begin
         pc   <= BRANCH_ADDR;
         pend <= 1'b0;
      end else begin
         pend <= issue;
         if (issue) begin
            pend_addr <= pc;
            pc        <= pc + ADDR_WIDTH'(1);
         end
      end
   end

   fetch_fifo #(
      .entry_t (entry_t),
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk        (CLK),
      .rst_n      (RESET),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (BRANCH_REQ),
      .head       (head),
      .count      (count),
      .empty      (empty)
   );

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Directed bench for rom_fetch_unit with a one-cycle synchronous ROM model (rom[a] = a ^ 8'hA0).
// The HALT scenario is only built when ROM_FETCH_HALT_EN is defined.
module tb_rom_fetch_unit;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [7:0] rom_addr;
   logic [7:0] rom_data;
   logic       branch_req;
   logic [7:0] branch_addr;
   logic [7:0] instr_data;
   logic [7:0] instr_addr;
   logic       instr_valid;
   logic       instr_ready;
`ifdef ROM_FETCH_HALT_EN
   logic       halt;
`endif

   logic [7:0] rom [256];
   int         compared   = 0;
   int         mismatched = 0;

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      rom_data <= rom[rom_addr];
   end

   rom_fetch_unit dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .ROM_ADDR    (rom_addr),
      .ROM_DATA    (rom_data),
      .BRANCH_REQ  (branch_req),
      .BRANCH_ADDR (branch_addr),
      .INSTR_DATA  (instr_data),
      .INSTR_ADDR  (instr_addr),
      .INSTR_VALID (instr_valid),
      .INSTR_READY (instr_ready)
`ifdef ROM_FETCH_HALT_EN
      ,
      .HALT        (halt)
`endif
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Leaves reset released 1 time unit after an edge, so the next tick is edge 1.
   task automatic do_reset(input logic ready);
      RESET       = 1'b0;
      branch_req  = 1'b0;
      branch_addr = 8'h00;
      instr_ready = ready;
`ifdef ROM_FETCH_HALT_EN
      halt        = 1'b0;
`endif
      tick();
      tick();
      RESET = 1'b1;
   endtask

   task automatic test_reset();
      RESET       = 1'b1;
      branch_req  = 1'b0;
      branch_addr = 8'h00;
      instr_ready = 1'b1;
`ifdef ROM_FETCH_HALT_EN
      halt        = 1'b0;
`endif
      #2;
      RESET = 1'b0;
      #1;
      compared++;
      if (rom_addr !== 8'h00) begin
         mismatched++;
         $display("[TB] FAIL reset_rom_addr: got %h expected 00", rom_addr);
      end
      compared++;
      if (instr_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid);
      end
      compared++;
      if (instr_data !== 8'h00) begin
         mismatched++;
         $display("[TB] FAIL reset_instr_data: got %h expected 00", instr_data);
      end
      compared++;
      if (instr_addr !== 8'h00) begin
         mismatched++;
         $display("[TB] FAIL reset_instr_addr: got %h expected 00", instr_addr);
      end
   endtask

   task automatic test_sequential();
      do_reset(1'b1);
      for (int k = 1; k <= 6; k++) begin
         tick();
         compared++;
         if (rom_addr !== k[7:0]) begin
            mismatched++;
            $display("[TB] FAIL seq_rom_addr edge %0d: got %h expected %h", k, rom_addr, k[7:0]);
         end
         compared++;
         if (instr_valid !== (k >= 2)) begin
            mismatched++;
            $display("[TB] FAIL seq_valid edge %0d: got %b expected %b", k, instr_valid, (k >= 2));
         end
         if (k >= 2) begin
            compared++;
            if (instr_addr !== 8'(k - 2) || instr_data !== (8'(k - 2) ^ 8'hA0)) begin
               mismatched++;
               $display("[TB] FAIL seq_byte edge %0d: got %h/%h expected %h/%h", k,
                        instr_addr, instr_data, 8'(k - 2), 8'(k - 2) ^ 8'hA0);
            end
         end
      end
   endtask

   task automatic test_fill_drain();
      do_reset(1'b0);
      repeat (8) tick();
      compared++;
      if (rom_addr !== 8'h04) begin
         mismatched++;
         $display("[TB] FAIL fill_stall_addr: got %h expected 04", rom_addr);
      end
      instr_ready = 1'b1;
      for (int t = 0; t < 8; t++) begin
         compared++;
         if (instr_valid !== 1'b1 || instr_addr !== t[7:0] || instr_data !== (t[7:0] ^ 8'hA0)) begin
            mismatched++;
            $display("[TB] FAIL drain_byte %0d: got v=%b %h/%h expected v=1 %h/%h", t,
                     instr_valid, instr_addr, instr_data, t[7:0], t[7:0] ^ 8'hA0);
         end
         tick();
      end
   endtask

   task automatic test_branch();
      do_reset(1'b0);
      repeat (4) tick();
      compared++;
      if (instr_valid !== 1'b1 || instr_addr !== 8'h00 || rom_addr !== 8'h04) begin
         mismatched++;
         $display("[TB] FAIL branch_setup: got v=%b head=%h rom=%h expected v=1 head=00 rom=04",
                  instr_valid, instr_addr, rom_addr);
      end
      branch_req  = 1'b1;
      branch_addr = 8'h40;
      instr_ready = 1'b1;
      tick();
      branch_req = 1'b0;
      compared++;
      if (instr_valid !== 1'b0 || rom_addr !== 8'h40) begin
         mismatched++;
         $display("[TB] FAIL branch_flush: got v=%b rom=%h expected v=0 rom=40", instr_valid, rom_addr);
      end
      tick();
      compared++;
      if (instr_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL branch_bubble2: got v=%b expected 0", instr_valid);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         compared++;
         if (instr_valid !== 1'b1 || instr_addr !== (8'h40 + 8'(i)) || instr_data !== ((8'h40 + 8'(i)) ^ 8'hA0)) begin
            mismatched++;
            $display("[TB] FAIL branch_target %0d: got v=%b %h/%h expected v=1 %h/%h", i,
                     instr_valid, instr_addr, instr_data, 8'h40 + 8'(i), (8'h40 + 8'(i)) ^ 8'hA0);
         end
      end
   endtask

   task automatic test_wrap();
      branch_req  = 1'b1;
      branch_addr = 8'hFE;
      tick();
      branch_req = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         compared++;
         if (instr_valid !== 1'b1 || instr_addr !== (8'hFE + 8'(i)) || instr_data !== ((8'hFE + 8'(i)) ^ 8'hA0)) begin
            mismatched++;
            $display("[TB] FAIL wrap_byte %0d: got v=%b %h/%h expected v=1 %h/%h", i,
                     instr_valid, instr_addr, instr_data, 8'hFE + 8'(i), (8'hFE + 8'(i)) ^ 8'hA0);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      branch_req  = 1'b1;
      branch_addr = 8'h10;
      tick();
      branch_addr = 8'h20;
      tick();
      branch_req = 1'b0;
      compared++;
      if (instr_valid !== 1'b0 || rom_addr !== 8'h20) begin
         mismatched++;
         $display("[TB] FAIL b2b_flush: got v=%b rom=%h expected v=0 rom=20", instr_valid, rom_addr);
      end
      tick();
      tick();
      compared++;
      if (instr_valid !== 1'b1 || instr_addr !== 8'h20 || instr_data !== 8'h80) begin
         mismatched++;
         $display("[TB] FAIL b2b_target: got v=%b %h/%h expected v=1 20/80", instr_valid, instr_addr, instr_data);
      end
   endtask

   task automatic test_reset_mid();
      do_reset(1'b0);
      repeat (3) tick();
      compared++;
      if (instr_valid !== 1'b1 || rom_addr !== 8'h03) begin
         mismatched++;
         $display("[TB] FAIL midreset_setup: got v=%b rom=%h expected v=1 rom=03", instr_valid, rom_addr);
      end
      #3;
      RESET = 1'b0;
      #1;
      compared++;
      if (instr_valid !== 1'b0 || rom_addr !== 8'h00) begin
         mismatched++;
         $display("[TB] FAIL midreset_async: got v=%b rom=%h expected v=0 rom=00", instr_valid, rom_addr);
      end
      tick();
      RESET       = 1'b1;
      instr_ready = 1'b1;
      tick();
      tick();
      compared++;
      if (instr_valid !== 1'b1 || instr_addr !== 8'h00 || instr_data !== 8'hA0) begin
         mismatched++;
         $display("[TB] FAIL midreset_restart: got v=%b %h/%h expected v=1 00/A0", instr_valid, instr_addr, instr_data);
      end
   endtask

`ifdef ROM_FETCH_HALT_EN
   task automatic test_halt();
      do_reset(1'b1);
      repeat (3) tick();
      halt = 1'b1;
      tick();
      compared++;
      if (instr_valid !== 1'b1 || instr_addr !== 8'h02 || rom_addr !== 8'h03) begin
         mismatched++;
         $display("[TB] FAIL halt_pending: got v=%b head=%h rom=%h expected v=1 head=02 rom=03",
                  instr_valid, instr_addr, rom_addr);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         compared++;
         if (instr_valid !== 1'b0 || rom_addr !== 8'h03) begin
            mismatched++;
            $display("[TB] FAIL halt_frozen %0d: got v=%b rom=%h expected v=0 rom=03", i, instr_valid, rom_addr);
         end
      end
      halt = 1'b0;
      tick();
      tick();
      compared++;
      if (instr_valid !== 1'b1 || instr_addr !== 8'h03 || instr_data !== 8'hA3) begin
         mismatched++;
         $display("[TB] FAIL halt_resume: got v=%b %h/%h expected v=1 03/A3", instr_valid, instr_addr, instr_data);
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < 256; i++) begin
         rom[i] = i[7:0] ^ 8'hA0;
      end
      test_reset();
      test_sequential();
      test_fill_drain();
      test_branch();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
`ifdef ROM_FETCH_HALT_EN
      test_halt();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
